alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//   Execute stage of the multicycle MIPS datapath. Consumes the two operands read from the
//   register file (data_out1/data_out2), performs the selected ALU, shift, multiply or
//   divide operation, and presents a registered result for register-file writeback (data_in3).
//   Single-cycle ops finish in one EXEC cycle; MULTU/DIVU iterate one bit per clock.
// PARAMETERS
//   WIDTH   32   operand/result width in bits (>=8)
//   CNT_W   6    iteration counter width, must satisfy 2**CNT_W > WIDTH
// PORTS
//   clock      in   1      system clock, rising edge
//   reset_n    in   1      synchronous active-low reset
//   start      in   1      request; accepted only while busy==0
//   op         in   4      operation code, sampled with start
//   a          in   WIDTH  operand A (rs), sampled with start
//   b          in   WIDTH  operand B (rt), sampled with start
//   shamt      in   5      shift amount, sampled with start
//   busy       out  1      high while an operation is in progress
//   done       out  1      one-cycle completion pulse
//   result     out  WIDTH  primary result (LO / quotient for MULTU/DIVU)
//   hi         out  WIDTH  HI product / remainder; 0 for non-MULTU/DIVU ops
//   zero       out  1      result == 0, updated with result
//   overflow   out  1      signed overflow (ADD/SUB only, else 0)
// BEHAVIOUR
//   Reset (reset_n==0 at a rising edge): state=IDLE; busy, done, zero, overflow=0;
//     result, hi, counter, internal operand regs = 0. Reset mid-operation aborts it, no done.
//   States: IDLE -> EXEC (op 0-A, D-F, or DIVU with b==0) | MUL (op B) | DIV (op C, b!=0).
//     EXEC -> IDLE after 1 cycle. MUL/DIV -> IDLE after WIDTH iterations. busy = (state!=IDLE).
//   Accept: start==1 at edge with state==IDLE latches op/a/b/shamt; start ignored while busy.
//   Latency (start edge = edge 0): EXEC ops write result/hi/flags and set done at edge 1;
//     MULTU/DIVU at edge WIDTH. done is high for exactly the cycle after that edge; busy
//     drops the same edge, so a new start is accepted at the next edge (back-to-back allowed).
//   result/hi/zero/overflow hold their value until the next completion; never change mid-op.
//   Op codes (unsigned unless noted; all arithmetic modulo 2**WIDTH):
//     0 ADD a+b   1 SUB a-b   2 AND   3 OR   4 XOR   5 NOR ~(a|b)
//     6 SLT signed a<b -> 1/0   7 SLTU unsigned a<b -> 1/0
//     8 SLL b<<shamt   9 SRL b>>shamt (zero fill)   A SRA b>>>shamt (sign fill)
//     B MULTU {hi,result}=a*b, shift-add, one bit of b per cycle
//     C DIVU  result=a/b, hi=a%b, restoring division, one quotient bit per cycle
//     D-F reserved: result=0, hi=0, zero=1, overflow=0, EXEC latency.
//   overflow: ADD when a,b same sign and sum sign differs; SUB when a,b differ in sign and
//     difference sign differs from a. Result is still written (wrapped).
//   DIVU by zero: EXEC latency; result = all ones, hi = a, overflow=0.
//   shamt>=WIDTH impossible for WIDTH=32; for other WIDTH use shamt mod WIDTH.
//   Writeback control (when to assert rw / enableFSM) stays in the control FSM; this block
//     only guarantees result is stable from done until the next accepted start completes.
// TESTING
//   ADD a=20 b=30 -> done at edge 1, result=50, zero=0, overflow=0, hi=0, busy 1 cycle.
//   SUB a=0x80000000 b=1 -> result=0x7FFFFFFF, overflow=1; SLT a=-1 b=1 -> result=1;
//     SLTU a=-1 b=1 -> result=0; SRA b=0x80000000 shamt=4 -> 0xF8000000.
//   MULTU a=0xFFFFFFFF b=2 -> busy 32 cycles, done at edge 32, hi=1, result=0xFFFFFFFE.
//   DIVU a=100 b=7 -> done at edge 32, result=14, hi=2; DIVU a=5 b=0 -> edge 1,
//     result=0xFFFFFFFF, hi=5.
//   start re-asserted with new op during MULTU -> ignored, original product delivered;
//     start held high continuously -> new op accepted the edge after each done.
//   reset_n=0 at edge 10 of a MULTU -> next cycle busy=0, done=0, result=0, hi=0; no done.

Source files
------------

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Purpose  : MIPS execute stage; single-cycle ALU/shift ops, iterative MULTU/DIVU
// Revision : 1.0
// ============================================================================
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DIV  = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_NOR   = 4'h5;
    localparam logic [3:0] OP_SLT   = 4'h6;
    localparam logic [3:0] OP_SLTU  = 4'h7;
    localparam logic [3:0] OP_SLL   = 4'h8;
    localparam logic [3:0] OP_SRL   = 4'h9;
    localparam logic [3:0] OP_SRA   = 4'hA;
    localparam logic [3:0] OP_MULTU = 4'hB;
    localparam logic [3:0] OP_DIVU  = 4'hC;

    state_t             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [4:0]         shamt_q, shamt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]   result_q, result_d, hi_q, hi_d;
    logic               zero_q, zero_d, ovf_q, ovf_d, done_q, done_d;

    logic [4:0]         sh_w;
    logic [WIDTH-1:0]   exec_res, exec_hi, sum_w, diff_w;
    logic               exec_ov;
    logic [WIDTH:0]     mul_sum, div_trial;
    logic               last_iter;

    always_comb begin
        sh_w     = 5'(32'(shamt_q) % WIDTH);
        sum_w    = a_q + b_q;
        diff_w   = a_q - b_q;
        exec_res = '0;
        exec_hi  = '0;
        exec_ov  = 1'b0;
        case (op_q)
            OP_ADD: begin
                exec_res = sum_w;
                exec_ov  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_w[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                exec_res = diff_w;
                exec_ov  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_w[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND:  exec_res = a_q & b_q;
            OP_OR:   exec_res = a_q | b_q;
            OP_XOR:  exec_res = a_q ^ b_q;
            OP_NOR:  exec_res = ~(a_q | b_q);
            OP_SLT:  exec_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            OP_SLTU: exec_res = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
            OP_SLL:  exec_res = b_q << sh_w;
            OP_SRL:  exec_res = b_q >> sh_w;
            OP_SRA:  exec_res = $signed(b_q) >>> sh_w;
            // Only the divide-by-zero case of DIVU is routed through EXEC.
            OP_DIVU: begin
                exec_res = '1;
                exec_hi  = a_q;
            end
            default: exec_res = '0;
        endcase
    end

    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, a_q} : '0);
        div_trial = {acc_hi_q, acc_lo_q[WIDTH-1]} - {1'b0, b_q};
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        shamt_d  = shamt_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        result_d = result_q;
        hi_d     = hi_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d     = op;
                    a_d      = a;
                    b_d      = b;
                    shamt_d  = shamt;
                    cnt_d    = '0;
                    acc_hi_d = '0;
                    if (op == OP_MULTU) begin
                        acc_lo_d = b;
                        state_d  = S_MUL;
                    end else if (op == OP_DIVU && b != '0) begin
                        acc_lo_d = a;
                        state_d  = S_DIV;
                    end else begin
                        state_d  = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                result_d = exec_res;
                hi_d     = exec_hi;
                zero_d   = (exec_res == '0);
                ovf_d    = exec_ov;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            S_MUL: begin
                // {acc_hi,acc_lo} shifts right; multiplier bits leave as product bits enter.
                acc_hi_d = mul_sum[WIDTH:1];
                acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                cnt_d    = cnt_q + 1'b1;
                if (last_iter) begin
                    result_d = acc_lo_d;
                    hi_d     = acc_hi_d;
                    zero_d   = (acc_lo_d == '0);
                    ovf_d    = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_DIV: begin
                // acc_hi holds the partial remainder, acc_lo dividend bits then quotient.
                if (!div_trial[WIDTH]) begin
                    acc_hi_d = div_trial[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_hi_d = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    result_d = acc_lo_d;
                    hi_d     = acc_hi_d;
                    zero_d   = (acc_lo_d == '0);
                    ovf_d    = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            shamt_q  <= '0;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            result_q <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            shamt_q  <= shamt_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign result   = result_q;
    assign hi       = hi_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_unit
// Purpose  : Directed and random checks of alu_exec_unit against an arithmetic model
// Revision : 1.0
// ============================================================================
module tb_alu_exec_unit;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    op = '0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [4:0]    shamt = '0;
    logic          busy, done, zero, overflow;
    logic [W-1:0]  result, hi;

    int checks = 0;
    int errors = 0;

    alu_exec_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .shamt(shamt), .busy(busy), .done(done), .result(result), .hi(hi),
        .zero(zero), .overflow(overflow)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                  input logic [4:0] sh, output logic [31:0] r,
                                  output logic [31:0] h, output logic ov, output int lat);
        longint s;
        longint unsigned p;
        r = '0; h = '0; ov = 1'b0; lat = 1;
        case (o)
            4'h0: begin
                s  = longint'($signed(x)) + longint'($signed(y));
                r  = x + y;
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'h1: begin
                s  = longint'($signed(x)) - longint'($signed(y));
                r  = x - y;
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'h2: r = x & y;
            4'h3: r = x | y;
            4'h4: r = x ^ y;
            4'h5: r = ~(x | y);
            4'h6: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'h7: r = (x < y) ? 32'd1 : 32'd0;
            4'h8: r = y << sh;
            4'h9: r = y >> sh;
            4'hA: begin
                s = longint'($signed(y));
                r = 32'(s >>> sh);
            end
            4'hB: begin
                p   = 64'(x) * 64'(y);
                r   = p[31:0];
                h   = p[63:32];
                lat = W;
            end
            4'hC: begin
                if (y == 0) begin
                    r = 32'hFFFF_FFFF;
                    h = x;
                end else begin
                    r   = x / y;
                    h   = x % y;
                    lat = W;
                end
            end
            default: r = '0;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [4:0] sh);
        logic [31:0] er, eh;
        logic        eov;
        int          elat, cyc;
        model(o, x, y, sh, er, eh, eov, elat);
        @(negedge clock);
        start = 1'b1; op = o; a = x; b = y; shamt = sh;
        @(posedge clock); #1;
        start = 1'b0;
        check({tag, ":busy"}, 64'(busy), 64'd1);
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(posedge clock); #1;
            cyc++;
        end
        check({tag, ":latency"}, 64'(cyc), 64'(elat));
        check({tag, ":idle"}, 64'(busy), 64'd0);
        check({tag, ":result"}, 64'(result), 64'(er));
        check({tag, ":hi"}, 64'(hi), 64'(eh));
        check({tag, ":zero"}, 64'(zero), 64'(er == 0));
        check({tag, ":ovf"}, 64'(overflow), 64'(eov));
        @(posedge clock); #1;
        check({tag, ":pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int  cyc;
        logic seen;
        logic [3:0] ro;
        logic [31:0] ra, rb;

        repeat (3) @(posedge clock);
        #1;
        check("rst:busy", 64'(busy), 64'd0);
        check("rst:done", 64'(done), 64'd0);
        check("rst:result", 64'(result), 64'd0);
        check("rst:hi", 64'(hi), 64'd0);
        check("rst:zero", 64'(zero), 64'd0);
        check("rst:ovf", 64'(overflow), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        run_op("add", 4'h0, 32'd20, 32'd30, 5'd0);
        check("add:const", 64'(result), 64'd50);
        run_op("sub_ovf", 4'h1, 32'h8000_0000, 32'd1, 5'd0);
        check("sub:const", 64'(result), 64'h7FFF_FFFF);
        run_op("slt", 4'h6, 32'hFFFF_FFFF, 32'd1, 5'd0);
        check("slt:const", 64'(result), 64'd1);
        run_op("sltu", 4'h7, 32'hFFFF_FFFF, 32'd1, 5'd0);
        run_op("sra", 4'hA, 32'd0, 32'h8000_0000, 5'd4);
        check("sra:const", 64'(result), 64'hF800_0000);
        run_op("multu", 4'hB, 32'hFFFF_FFFF, 32'd2, 5'd0);
        check("multu:const", 64'({hi, result}), 64'h1_FFFF_FFFE);
        run_op("divu", 4'hC, 32'd100, 32'd7, 5'd0);
        check("divu:const", 64'({hi, result}), {32'd2, 32'd14});
        run_op("divu0", 4'hC, 32'd5, 32'd0, 5'd0);
        run_op("rsvd", 4'hE, 32'h1234, 32'h5678, 5'd3);
        run_op("add_ovf", 4'h0, 32'h7FFF_FFFF, 32'd1, 5'd0);

        for (int i = 0; i < 40; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            run_op("rand", ro, ra, rb, 5'($urandom));
        end

        // New request during MULTU must be ignored
        @(negedge clock);
        start = 1'b1; op = 4'hB; a = 32'hFFFF_FFFF; b = 32'd2; shamt = '0;
        @(posedge clock); #1;
        op = 4'h0; a = 32'd5; b = 32'd6;
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(posedge clock); #1;
            cyc++;
        end
        start = 1'b0;
        check("ign:latency", 64'(cyc), 64'd32);
        check("ign:product", 64'({hi, result}), 64'h1_FFFF_FFFE);
        @(posedge clock); #1;

        // Start held high: back-to-back acceptance right after each done
        @(negedge clock);
        start = 1'b1; op = 4'h0; a = 32'd1; b = 32'd2;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("b2b:done1", 64'(done), 64'd1);
        check("b2b:res1", 64'(result), 64'd3);
        op = 4'h1; a = 32'd10; b = 32'd3;
        @(posedge clock); #1;
        check("b2b:busy2", 64'(busy), 64'd1);
        check("b2b:nodone", 64'(done), 64'd0);
        @(posedge clock); #1;
        start = 1'b0;
        check("b2b:done2", 64'(done), 64'd1);
        check("b2b:res2", 64'(result), 64'd7);
        @(posedge clock); #1;

        // Reset at edge 10 of a MULTU aborts it
        @(negedge clock);
        start = 1'b1; op = 4'hB; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock); #1;
        check("abort:busy", 64'(busy), 64'd0);
        check("abort:done", 64'(done), 64'd0);
        check("abort:result", 64'(result), 64'd0);
        check("abort:hi", 64'(hi), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clock); #1;
            seen = seen | done | busy;
        end
        check("abort:quiet", 64'(seen), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
